// File: rtl/ssdt_arb_pkg.sv
// Shared types and default sizes for the SSDT round-robin arbiter.
package ssdt_arb_pkg;

  localparam int unsigned NUM_REQ_DEF     = 4;
  localparam int unsigned DATA_W_DEF      = 4;
  localparam int unsigned TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/ssdt_arbiter_if.sv
// Requester and SSDT pin bundle. The arbiter uses the slave view; the
// requester agents and the SSDT instance use the master view.
interface ssdt_arbiter_if
  import ssdt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic [DATA_W-1:0]         ssdt_in_data;
  logic                      ssdt_in_valid;
  logic                      ssdt_out_valid;
  logic [DATA_W-1:0]         ssdt_out_data;

  modport master (
    output req_valid, req_data, ssdt_out_valid, ssdt_out_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, ssdt_in_data, ssdt_in_valid
  );

  modport slave (
    input  req_valid, req_data, ssdt_out_valid, ssdt_out_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, ssdt_in_data, ssdt_in_valid
  );

endinterface

// File: rtl/ssdt_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module ssdt_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             any_c
);

  int unsigned idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    idx         = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_c && req[IDX_W'(idx)]) begin
        any_c                 = 1'b1;
        grant_c[IDX_W'(idx)]  = 1'b1;
        grant_idx_c           = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ssdt_arbiter.sv
// Round-robin arbiter sharing one SSDT datapath between NUM_REQ requesters,
// one transaction in flight. Optional WAIT timeout: SSDT_ARB_TIMEOUT_EN.
module ssdt_arbiter
  import ssdt_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NUM_REQ_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic           clk,
  input logic           rst,
  ssdt_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("ssdt_arbiter: unsupported parameter set");
    end
  endgenerate

  arb_state_e          state, state_nxt;
  logic [IDX_W-1:0]    rr_ptr, owner, grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                any_req;
  logic                accept, resp_ok, resp_to, cnt_hit;
  logic [DATA_W-1:0]   in_data_q, rsp_data_q;
  logic                in_valid_q, rsp_err_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;

  ssdt_rr_pick #(.N(NUM_REQ)) u_pick (
    .req         (bus.req_valid),
    .ptr         (rr_ptr),
    .grant_c     (grant),
    .grant_idx_c (grant_idx),
    .any_c       (any_req)
  );

`ifdef SSDT_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles; the TIMEOUT_CYC-th WAIT cycle without out_valid aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wait_cnt <= '0;
    else if (state != WAIT) wait_cnt <= '0;
    else                    wait_cnt <= wait_cnt + 1'b1;
  end

  assign cnt_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign cnt_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    resp_ok       = 1'b0;
    resp_to       = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = grant;
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A response arriving on the limit cycle still wins over the timeout.
        if (bus.ssdt_out_valid) begin
          resp_ok   = 1'b1;
          state_nxt = RESP;
        end else if (cnt_hit) begin
          resp_to   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      owner       <= '0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      in_valid_q  <= accept;
      rsp_valid_q <= (resp_ok || resp_to) ? (NUM_REQ'(1) << owner) : '0;
      if (accept) begin
        owner     <= grant_idx;
        in_data_q <= bus.req_data[32'(grant_idx)*DATA_W +: DATA_W];
      end
      if (resp_ok) begin
        rsp_data_q <= bus.ssdt_out_data;
        rsp_err_q  <= 1'b0;
      end else if (resp_to) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
      if (state == RESP)
        rr_ptr <= (32'(owner) == NUM_REQ - 1) ? '0 : IDX_W'(32'(owner) + 1);
    end
  end

  assign bus.ssdt_in_valid = in_valid_q;
  assign bus.ssdt_in_data  = in_data_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ssdt_arbiter.sv
// Randomized bench for ssdt_arbiter against a transaction-level model of the
// arbitration order and response timing.
module tb_ssdt_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned TO = 8;
`ifdef SSDT_ARB_TIMEOUT_EN
  localparam int unsigned LAT_MAX = TO;
`else
  localparam int unsigned LAT_MAX = 6;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ssdt_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  ssdt_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model state: one transaction at a time, described by accept cycle and latency.
  int              cyc = 0;
  bit              busy, no_resp;
  int              t_acc, lat, owner_m, ptr_m;
  logic [DW-1:0]   data_m, exp_rdata;
  logic            exp_err;
  bit              pending [N];
  logic [DW-1:0]   pdata [N];
  bit              granted_last [N];
  bit              rand_req, hold_all, stray_en, force_ov;
  int              fixed_lat, noresp_mode;
  int              grant_log [$];

  function automatic logic [DW-1:0] ssdt_fn(input logic [DW-1:0] d);
    return ~d;
  endfunction

  task automatic model_reset();
    busy = 0; ptr_m = 0; exp_rdata = '0; exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      pending[i] = 0; granted_last[i] = 0; pdata[i] = '0;
    end
    bus.req_valid = '0; bus.req_data = '0;
    bus.ssdt_out_valid = 1'b0; bus.ssdt_out_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] exp_ready, exp_rv;
    bit           exp_iv;
    int           w, idx;
    @(posedge clk);
    #1;
    cyc++;
    if (busy && cyc == t_acc + 3 + lat) busy = 0;
    for (int i = 0; i < N; i++) begin
      if (granted_last[i]) begin pending[i] = 0; granted_last[i] = 0; end
      if (!pending[i] && (hold_all || (rand_req && $urandom_range(0, 3) == 0))) begin
        pending[i] = 1; pdata[i] = DW'($urandom);
      end else if (pending[i] && rand_req && $urandom_range(0, 15) == 0) begin
        pending[i] = 0;
      end
      bus.req_valid[i]          = pending[i];
      bus.req_data[i*DW +: DW]  = pdata[i];
    end
    exp_ready = '0;
    w = -1;
    if (!busy) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (w < 0 && pending[idx]) w = idx;
      end
    end
    if (w >= 0) begin
      busy = 1; t_acc = cyc; owner_m = w; data_m = pdata[w];
      no_resp = (noresp_mode == 1) || (noresp_mode == 2 && $urandom_range(0, 5) == 0);
      lat = no_resp ? TO : (fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, LAT_MAX)));
      exp_ready[w] = 1'b1;
      ptr_m = (w + 1) % N;
      granted_last[w] = 1;
      grant_log.push_back(w);
    end
    bus.ssdt_out_valid = 1'b0;
    bus.ssdt_out_data  = DW'($urandom);
    if (busy && !no_resp && cyc == t_acc + 1 + lat) begin
      bus.ssdt_out_valid = 1'b1;
      bus.ssdt_out_data  = ssdt_fn(data_m);
    end else if (!(busy && cyc >= t_acc + 2 && cyc <= t_acc + 1 + lat)) begin
      if (force_ov || (stray_en && $urandom_range(0, 5) == 0)) bus.ssdt_out_valid = 1'b1;
    end
    force_ov = 0;
    exp_iv = busy && cyc == t_acc + 1;
    exp_rv = '0;
    if (busy && cyc == t_acc + 2 + lat) begin
      exp_rv[owner_m] = 1'b1;
      exp_rdata = no_resp ? '0 : ssdt_fn(data_m);
      exp_err   = no_resp;
    end
    @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("ssdt_in_valid", 32'(bus.ssdt_in_valid), 32'(exp_iv));
    if (exp_iv) check("ssdt_in_data", 32'(bus.ssdt_in_data), 32'(data_m));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp_rdata));
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    check({tag, "_in_valid"}, 32'(bus.ssdt_in_valid), 32'd0);
    check({tag, "_in_data"}, 32'(bus.ssdt_in_data), 32'd0);
  endtask

  initial begin
    rand_req = 0; hold_all = 0; stray_en = 0; force_ov = 0;
    fixed_lat = 0; noresp_mode = 0;
    rst = 1'b1;
    model_reset();
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request: requester 1, data 5, SSDT latency 3.
    grant_log.delete();
    pending[1] = 1; pdata[1] = 4'h5; fixed_lat = 3;
    repeat (8) step();
    check("single_grant_cnt", 32'(grant_log.size()), 32'd1);
    check("single_rsp_data", 32'(bus.rsp_data), 32'hA);

    // All four held valid from reset.
    do_reset();
    grant_log.delete();
    fixed_lat = 0; hold_all = 1;
    repeat (80) step();
    hold_all = 0;
    repeat (50) step();
    check("all4_enough_grants", 32'(grant_log.size() >= 5), 32'd1);
    for (int k = 0; k < 5 && k < grant_log.size(); k++)
      check("all4_order", 32'(grant_log[k]), 32'(k % 4));
    for (int k = 1; k < grant_log.size(); k++)
      check("all4_no_repeat", 32'(grant_log[k] == grant_log[k-1]), 32'd0);

    // Pointer wrap: serve 2 so the pointer sits at 3, then 0 and 2 together.
    do_reset();
    grant_log.delete();
    fixed_lat = 2;
    pending[2] = 1; pdata[2] = 4'h7;
    repeat (8) step();
    pending[0] = 1; pdata[0] = 4'h1;
    pending[2] = 1; pdata[2] = 4'hC;
    repeat (16) step();
    check("wrap_cnt", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check("wrap_first", 32'(grant_log[1]), 32'd0);
      check("wrap_second", 32'(grant_log[2]), 32'd2);
    end

    // Reset during WAIT: aborted transaction never responds.
    do_reset();
    fixed_lat = 5;
    pending[3] = 1; pdata[3] = 4'h9;
    for (int k = 0; k < 20 && !(busy && cyc == t_acc + 3); k++) step();
    check("rst_wait_reached", 32'(busy && cyc == t_acc + 3), 32'd1);
    bus.req_valid = '0;
    rst = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus.ssdt_out_valid = (k == 1);
      bus.ssdt_out_data  = ssdt_fn(4'h9);
      @(negedge clk);
      check("late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("late_in_valid", 32'(bus.ssdt_in_valid), 32'd0);
    end
    fixed_lat = 1;
    pending[0] = 1; pdata[0] = 4'h3;
    repeat (8) step();

    // Stray out_valid while IDLE, then a normal transaction.
    force_ov = 1;
    repeat (4) step();
    fixed_lat = 4;
    pending[2] = 1; pdata[2] = 4'hE;
    repeat (10) step();

`ifdef SSDT_ARB_TIMEOUT_EN
    // SSDT never answers: timeout after TO WAIT cycles, then normal service.
    noresp_mode = 1;
    pending[1] = 1; pdata[1] = 4'h6;
    repeat (3 + TO + 2) step();
    check("timeout_err_held", 32'(bus.rsp_err), 32'd1);
    noresp_mode = 0;
    fixed_lat = TO;
    pending[3] = 1; pdata[3] = 4'h2;
    repeat (3 + TO + 2) step();
    fixed_lat = 2;
    pending[0] = 1; pdata[0] = 4'hB;
    repeat (8) step();
    noresp_mode = 2;
`endif

    // Random traffic with withdrawals and stray SSDT pulses.
    fixed_lat = 0; rand_req = 1; stray_en = 1;
    repeat (1500) step();
    rand_req = 0; stray_en = 0; noresp_mode = 0;
    for (int i = 0; i < N; i++) pending[i] = 0;
    repeat (3 + LAT_MAX + 4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
